glb_ld_strm_tx: RTL
===================

Name: glb_ld_strm_tx

Overview:
- GLB-side load-stream transmitter: drives one PRR data input port (io16_g2io, io1_g2io valid) from GLB bank memory using a nested-loop address generator.
- Supports a cycle-scheduled valid mode and a ready/valid handshake mode, honouring the PRR's ready (io1_io2g).
- One instance per PRR input lane. Configured and started by the GLB load-DMA controller.

Parameters:
- DATA_WIDTH, 16, stream word width
- ADDR_WIDTH, 16, bank memory word-address width
- LOOP_LEVEL, 4, max loop nesting
- CNT_WIDTH, 16, extent/stride/cycle counter width
- FIFO_DEPTH, 4, ready/valid-mode buffer depth (power of 2, >=2)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- stall  in  1  freezes all state when high
- cfg_start  in  1  one-cycle start pulse; ignored unless idle
- cfg_mode  in  2  0 off, 1 valid, 2 ready/valid, 3 reserved (treated as off)
- cfg_dim  in  3  active loop levels, 0..LOOP_LEVEL
- cfg_start_addr  in  ADDR_WIDTH  base word address
- cfg_extent  in  LOOP_LEVEL*CNT_WIDTH  per-level extent, level 0 innermost
- cfg_data_stride  in  LOOP_LEVEL*ADDR_WIDTH  per-level address stride
- cfg_cycle_stride  in  LOOP_LEVEL*CNT_WIDTH  per-level cycle stride (valid mode only)
- mem_rd_en  out  1  memory read strobe
- mem_rd_addr  out  ADDR_WIDTH  memory read address
- mem_rd_data  in  DATA_WIDTH  read data, valid exactly 1 cycle after mem_rd_en
- io16_g2io  out  DATA_WIDTH  stream data to PRR
- io1_g2io  out  1  stream valid to PRR
- io1_io2g  in  1  PRR ready
- strm_data_flush  out  1  one-cycle flush pulse to PRR
- busy  out  1  high in any non-IDLE state
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs 0, FSM IDLE, counters/FIFO cleared. Reset mid-stream aborts immediately; no done pulse.
- Config is sampled on cfg_start. Later changes have no effect until the next start.
- FSM:
  - IDLE -> FLUSH on cfg_start with mode 1 or 2.
  - Mode 0/3 start: ignored.
  - FLUSH: strm_data_flush=1 for exactly one cycle -> RUN.
  - RUN: issue reads until the last element is issued -> DRAIN.
  - DRAIN: until the last word is delivered, then done=1 for one cycle -> IDLE.
  - cfg_dim=0: FLUSH -> DRAIN (zero words) -> done the cycle after FLUSH.
- Address generation:
  - Element k iterators i0..i(dim-1), incremented innermost first.
  - addr = start_addr + sum(i_l*data_stride_l), mod 2^ADDR_WIDTH.
  - Extent value 0 is treated as 1.
  - Total elements = product of extents over active levels.
- Valid mode:
  - T0 = first RUN cycle. Cycle counter t starts at 0 in T0.
  - sched_k = sum(i_l*cycle_stride_l), mod 2^CNT_WIDTH.
  - Element k is issued (mem_rd_en=1) in the cycle t == max(sched_k, issue_{k-1}+1). A non-increasing schedule degrades to back-to-back issue.
  - Data is registered, and io1_g2io=1 with io16_g2io=word for exactly one cycle, 2 cycles after issue. io1_io2g is ignored.
  - When io1_g2io=0, io16_g2io=0.
- Ready/valid mode:
  - Issue a read each non-stalled RUN cycle while FIFO occupancy + in-flight reads < FIFO_DEPTH. Read data is pushed into the FIFO.
  - io1_g2io = FIFO nonempty & !stall; io16_g2io = FIFO head.
  - Transfer occurs in a cycle with io1_g2io & io1_io2g; the head then pops.
  - While valid and not ready, data is held stable.
  - Push and pop in the same cycle are allowed; at full with a pop the issue is permitted.
- Stall:
  - All counters, FSM, FIFO and in-flight data freeze.
  - mem_rd_en=0, io1_g2io=0 (data held). The in-flight memory return is captured into a holding register.
  - In valid mode a word due during a stall is presented in the first non-stall cycle, and the whole schedule shifts by the stall length.
  - Stall during FLUSH extends FLUSH, pulse included.
- done asserts the cycle after the final delivery (valid-mode last valid, or ready/valid last transfer).
- cfg_start while busy: ignored.

Test Plan:
- Valid mode, dim=1, extent 4, data_stride 1, cycle_stride 2, start 0x10, mem returns addr -> mem_rd_addr 0x10..0x13 at T0,+2,+4,+6; io1_g2io at T0+2,+4,+6,+8 with data 0x10..0x13; done at T0+9; strm_data_flush at T0-1.
- 2D valid mode, extents {2,3}, data_stride {1,8}, cycle_stride {1,4} -> addresses 0,1,8,9,16,17, issued at t=0,1,4,5,8,9.
- Ready/valid, 8 words, io1_io2g toggling 1,0,1,0 -> 8 words delivered in order, data stable across not-ready cycles, never more than 4 reads outstanding.
- Ready/valid, ready held 0 for 20 cycles then 1 -> exactly 4 reads issued while blocked; then words stream one per cycle; done after the 8th transfer.
- Valid mode, cycle_stride 0, extent 5 -> back-to-back issue t=0..4, valid 5 consecutive cycles.
- stall for 3 cycles mid-stream in each mode -> no lost or duplicated words, valid-mode schedule shifted by 3; reset mid-RUN -> all outputs 0 next cycle, no done.

Source files
------------

// File: rtl/glb_ld_strm_tx.sv
// GLB load-stream transmitter: walks a nested-loop address pattern over bank memory
// and streams the words to one PRR input lane in scheduled-valid or ready/valid mode.
module glb_ld_strm_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int LOOP_LEVEL = 4,
  parameter int CNT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             stall,
  input  logic                             cfg_start,
  input  logic [1:0]                       cfg_mode,
  input  logic [2:0]                       cfg_dim,
  input  logic [ADDR_WIDTH-1:0]            cfg_start_addr,
  input  logic [LOOP_LEVEL*CNT_WIDTH-1:0]  cfg_extent,
  input  logic [LOOP_LEVEL*ADDR_WIDTH-1:0] cfg_data_stride,
  input  logic [LOOP_LEVEL*CNT_WIDTH-1:0]  cfg_cycle_stride,
  output logic                             mem_rd_en,
  output logic [ADDR_WIDTH-1:0]            mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]            mem_rd_data,
  output logic [DATA_WIDTH-1:0]            io16_g2io,
  output logic                             io1_g2io,
  input  logic                             io1_io2g,
  output logic                             strm_data_flush,
  output logic                             busy,
  output logic                             done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FLUSH, RUN, DRAIN} state_t;

  state_t                  state;
  logic                    mode_rv;
  logic [2:0]              dim_q;
  logic [ADDR_WIDTH-1:0]   start_q;
  logic [CNT_WIDTH-1:0]    ext_m1   [LOOP_LEVEL];
  logic [ADDR_WIDTH-1:0]   dstride  [LOOP_LEVEL];
  logic [CNT_WIDTH-1:0]    cstride  [LOOP_LEVEL];
  logic [CNT_WIDTH-1:0]    iter     [LOOP_LEVEL];
  logic [CNT_WIDTH-1:0]    iter_nxt [LOOP_LEVEL];
  logic [ADDR_WIDTH-1:0]   doff     [LOOP_LEVEL];
  logic [ADDR_WIDTH-1:0]   doff_nxt [LOOP_LEVEL];
  logic [CNT_WIDTH-1:0]    coff     [LOOP_LEVEL];
  logic [CNT_WIDTH-1:0]    coff_nxt [LOOP_LEVEL];
  logic [CNT_WIDTH-1:0]    t_cnt;
  logic                    t_ovf;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [CNT_WIDTH-1:0]    sched;
  logic                    last_elem;
  logic                    carry;

  logic                    rd_pending;
  logic                    hold_valid;
  logic [DATA_WIDTH-1:0]   hold_data;
  logic                    ret_valid;
  logic [DATA_WIDTH-1:0]   ret_data;
  logic [DATA_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W:0]          occ;
  logic [PTR_W+1:0]        fill;
  logic                    fifo_ne;
  logic                    pop;
  logic                    rv_room;
  logic                    sched_ok;
  logic                    issue;

  // Offsets of inactive levels stay zero, so summing every level is safe.
  always_comb begin
    addr  = start_q;
    sched = '0;
    for (int l = 0; l < LOOP_LEVEL; l++) begin
      addr  = addr + doff[l];
      sched = sched + coff[l];
    end
  end

  always_comb begin
    carry     = 1'b1;
    last_elem = 1'b1;
    for (int l = 0; l < LOOP_LEVEL; l++) begin
      iter_nxt[l] = iter[l];
      doff_nxt[l] = doff[l];
      coff_nxt[l] = coff[l];
      if (l < int'(dim_q)) begin
        if (iter[l] != ext_m1[l]) last_elem = 1'b0;
        if (carry) begin
          if (iter[l] == ext_m1[l]) begin
            iter_nxt[l] = '0;
            doff_nxt[l] = '0;
            coff_nxt[l] = '0;
          end else begin
            iter_nxt[l] = iter[l] + CNT_WIDTH'(1);
            doff_nxt[l] = doff[l] + dstride[l];
            coff_nxt[l] = coff[l] + cstride[l];
            carry       = 1'b0;
          end
        end
      end
    end
  end

  // A return that lands during a stall is parked in hold_data until the stall ends.
  assign ret_valid = rd_pending | hold_valid;
  assign ret_data  = hold_valid ? hold_data : mem_rd_data;
  assign fifo_ne   = (occ != '0);
  assign io1_g2io  = fifo_ne & ~stall;
  assign io16_g2io = fifo_ne ? fifo_mem[rd_ptr] : '0;
  assign pop       = io1_g2io & (~mode_rv | io1_io2g);
  assign fill      = {1'b0, occ} + (PTR_W+2)'(ret_valid) - (PTR_W+2)'(pop);
  assign rv_room   = (fill < (PTR_W+2)'(FIFO_DEPTH));
  assign sched_ok  = t_ovf | (t_cnt >= sched);
  assign issue     = (state == RUN) & ~stall & (mode_rv ? rv_room : sched_ok);

  assign mem_rd_en       = issue;
  assign mem_rd_addr     = issue ? addr : '0;
  assign strm_data_flush = (state == FLUSH);
  assign busy            = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      done    <= 1'b0;
      mode_rv <= 1'b0;
      dim_q   <= '0;
      start_q <= '0;
      t_cnt   <= '0;
      t_ovf   <= 1'b0;
      for (int l = 0; l < LOOP_LEVEL; l++) begin
        ext_m1[l]  <= '0;
        dstride[l] <= '0;
        cstride[l] <= '0;
        iter[l]    <= '0;
        doff[l]    <= '0;
        coff[l]    <= '0;
      end
    end else begin
      done <= 1'b0;
      if (!stall) begin
        case (state)
          IDLE: begin
            if (cfg_start && (cfg_mode == 2'd1 || cfg_mode == 2'd2)) begin
              mode_rv <= (cfg_mode == 2'd2);
              dim_q   <= cfg_dim;
              start_q <= cfg_start_addr;
              for (int l = 0; l < LOOP_LEVEL; l++) begin
                ext_m1[l]  <= (cfg_extent[l*CNT_WIDTH +: CNT_WIDTH] == '0) ? '0 :
                              cfg_extent[l*CNT_WIDTH +: CNT_WIDTH] - CNT_WIDTH'(1);
                dstride[l] <= cfg_data_stride[l*ADDR_WIDTH +: ADDR_WIDTH];
                cstride[l] <= cfg_cycle_stride[l*CNT_WIDTH +: CNT_WIDTH];
                iter[l]    <= '0;
                doff[l]    <= '0;
                coff[l]    <= '0;
              end
              state <= FLUSH;
            end
          end
          FLUSH: begin
            if (dim_q == '0) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              t_cnt <= '0;
              t_ovf <= 1'b0;
            end
          end
          RUN: begin
            t_cnt <= t_cnt + CNT_WIDTH'(1);
            if (&t_cnt) t_ovf <= 1'b1;
            if (issue) begin
              iter <= iter_nxt;
              doff <= doff_nxt;
              coff <= coff_nxt;
              if (last_elem) state <= DRAIN;
            end
          end
          DRAIN: begin
            if (pop && occ == (PTR_W+1)'(1) && !ret_valid) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pending <= 1'b0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else if (!stall) begin
      rd_pending <= issue;
      hold_valid <= 1'b0;
      if (ret_valid) begin
        fifo_mem[wr_ptr] <= ret_data;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      occ <= occ + (PTR_W+1)'(ret_valid) - (PTR_W+1)'(pop);
    end else if (rd_pending) begin
      hold_data  <= mem_rd_data;
      hold_valid <= 1'b1;
      rd_pending <= 1'b0;
    end
  end

endmodule
